axi_phase_sequencer: RTL and testbench



---
 rtl/axi_phase_seq_pkg.sv | 56 +++++
 rtl/axi_phase_done_join.sv | 40 ++++
 rtl/axi_phase_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_axi_phase_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_phase_seq_pkg.sv
// ---------------------------------------------------------------------------
// axi_phase_seq_pkg
// Shared types and helpers for the AXI4 bench phase sequencer.
//   phase_seq_state_t : sequencer FSM states (BV_* only exist when the
//                       BYTE_VERIFICATION_PHASE_EN macro is defined)
//   calc_num_phases   : number of phases for a given test / phase count
//   state_to_string   : printable state name for the debug logger
// ---------------------------------------------------------------------------
package axi_phase_seq_pkg;

   // Encodings are fixed so that logged state values stay comparable
   // between builds with and without the byte verification phase.
   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      WR_START = 4'd1,
      WR_WAIT  = 4'd2,
      RD_START = 4'd3,
      RD_WAIT  = 4'd4,
      NEXT     = 4'd5,
`ifdef BYTE_VERIFICATION_PHASE_EN
      BV_START = 4'd6,
      BV_WAIT  = 4'd7,
`endif
      DONE     = 4'd8,
      ERROR    = 4'd9
   } phase_seq_state_t;

   localparam int DEFAULT_TOTAL_TEST_COUNT = 64;
   localparam int DEFAULT_PHASE_TEST_COUNT = 8;
   localparam int DEFAULT_NUM_PHASES = DEFAULT_TOTAL_TEST_COUNT / DEFAULT_PHASE_TEST_COUNT;

   // A zero phase size would divide by zero; report zero phases instead so the
   // elaboration check in the top level can flag it.
   function automatic int calc_num_phases(input int total, input int per_phase);
      return (per_phase > 0) ? (total / per_phase) : 0;
   endfunction

   function automatic string state_to_string(input phase_seq_state_t s);
      case (s)
         IDLE:     return "IDLE";
         WR_START: return "WR_START";
         WR_WAIT:  return "WR_WAIT";
         RD_START: return "RD_START";
         RD_WAIT:  return "RD_WAIT";
         NEXT:     return "NEXT";
`ifdef BYTE_VERIFICATION_PHASE_EN
         BV_START: return "BV_START";
         BV_WAIT:  return "BV_WAIT";
`endif
         DONE:     return "DONE";
         ERROR:    return "ERROR";
         default:  return "UNKNOWN";
      endcase
   endfunction

endpackage

// File: rtl/axi_phase_done_join.sv
// ---------------------------------------------------------------------------
// axi_phase_done_join
// Joins two single-cycle done pulses that may arrive in any order or together.
//   clk, rst    : clock, synchronous active-high reset
//   clear       : drops both remembered pulses (used on the start cycle)
//   capture_en  : pulses are only remembered / reported while this is high
//   done_a/b    : done pulses from the two channels
//   all_done    : high in the cycle the pair is complete, including the
//                 cycle in which the second pulse arrives
// ---------------------------------------------------------------------------
module axi_phase_done_join (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic capture_en,
   input  logic done_a,
   input  logic done_b,
   output logic all_done
);

   logic seen_a;
   logic seen_b;

   // Remember each pulse until the pair is consumed. Pulses outside the
   // capture window are dropped so nothing can be pre-loaded.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         seen_a <= 1'b0;
         seen_b <= 1'b0;
      end else if (capture_en) begin
         if (done_a) seen_a <= 1'b1;
         if (done_b) seen_b <= 1'b1;
      end
   end

   // Live pulses are OR-ed in so the caller can advance in the same cycle
   // the last done arrives.
   assign all_done = capture_en && (seen_a || done_a) && (seen_b || done_b);

endmodule

// File: rtl/axi_phase_sequencer.sv
// ---------------------------------------------------------------------------
// axi_phase_sequencer
// Steps the AXI4 bench through its test phases: per phase it pulses the write
// channel starts, waits for AW and W done, pulses the read channel starts,
// waits for AR and R done, then advances current_phase. A watchdog flags any
// wait that exceeds PHASE_TIMEOUT_CYCLES (0 disables it).
//
// Optional build macro BYTE_VERIFICATION_PHASE_EN adds a final byte
// verification phase after the last test phase.
//
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   start                        : level, sampled in IDLE
//   *_phase_done                 : done pulses from AW / W / AR / R agents
//   *_phase_start                : one-cycle start pulses to the agents
//   current_phase                : 0-based phase index
//   test_execution_completed     : sticky, set once the last phase is done
//   phase_timeout                : sticky watchdog error
//   byte_verification_phase_*    : (macro only) BV start / done / done latch
//   busy                         : high outside IDLE, DONE and ERROR
// ---------------------------------------------------------------------------
module axi_phase_sequencer
   import axi_phase_seq_pkg::*;
#(
   parameter int TOTAL_TEST_COUNT     = 64,
   parameter int PHASE_TEST_COUNT     = 8,
   parameter int PHASE_TIMEOUT_CYCLES = 100000,
   parameter int PHASE_W              = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               write_addr_phase_done,
   input  logic               write_data_phase_done,
   input  logic               read_addr_phase_done,
   input  logic               read_data_phase_done,
   output logic               write_addr_phase_start,
   output logic               write_data_phase_start,
   output logic               read_addr_phase_start,
   output logic               read_data_phase_start,
   output logic [PHASE_W-1:0] current_phase,
   output logic               test_execution_completed,
   output logic               phase_timeout,
`ifdef BYTE_VERIFICATION_PHASE_EN
   output logic               byte_verification_phase_start,
   input  logic               byte_verification_phase_done,
   output logic               byte_verification_phase_done_latched,
`endif
   output logic               busy
);

   localparam int NUM_PHASES = calc_num_phases(TOTAL_TEST_COUNT, PHASE_TEST_COUNT);
   localparam int WD_W = (PHASE_TIMEOUT_CYCLES > 1) ? $clog2(PHASE_TIMEOUT_CYCLES) : 1;
   localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(NUM_PHASES - 1);
   // The counter reads N-1 during the N-th cycle of a wait, so the limit
   // compare fires on the last allowed cycle.
   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(PHASE_TIMEOUT_CYCLES - 1);

   if ((PHASE_TEST_COUNT <= 0) || (TOTAL_TEST_COUNT % PHASE_TEST_COUNT != 0)) begin : g_bad_ratio
      $error("axi_phase_sequencer: TOTAL_TEST_COUNT must be a multiple of PHASE_TEST_COUNT");
   end
   if (NUM_PHASES > (1 << PHASE_W)) begin : g_bad_width
      $error("axi_phase_sequencer: NUM_PHASES does not fit in PHASE_W bits");
   end

   phase_seq_state_t state;
   phase_seq_state_t next_state;

   logic            wr_all_done;
   logic            rd_all_done;
   logic            in_wait;
   logic            timeout_hit;
   logic            last_phase;
   logic [WD_W-1:0] wd_cnt;

   axi_phase_done_join u_write_join (
      .clk        (clk),
      .rst        (rst),
      .clear      (state == WR_START),
      .capture_en (state == WR_WAIT),
      .done_a     (write_addr_phase_done),
      .done_b     (write_data_phase_done),
      .all_done   (wr_all_done)
   );

   axi_phase_done_join u_read_join (
      .clk        (clk),
      .rst        (rst),
      .clear      (state == RD_START),
      .capture_en (state == RD_WAIT),
      .done_a     (read_addr_phase_done),
      .done_b     (read_data_phase_done),
      .all_done   (rd_all_done)
   );

`ifdef BYTE_VERIFICATION_PHASE_EN
   assign in_wait = (state == WR_WAIT) || (state == RD_WAIT) || (state == BV_WAIT);
`else
   assign in_wait = (state == WR_WAIT) || (state == RD_WAIT);
`endif
   assign timeout_hit = (PHASE_TIMEOUT_CYCLES != 0) && in_wait && (wd_cnt == WD_LIMIT);
   assign last_phase  = (current_phase == LAST_PHASE);

   // State register; reset wins over every transition.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Next-state logic. In every wait state the watchdog is checked first so a
   // done arriving on the timeout cycle cannot rescue the phase.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:     if (start) next_state = WR_START;
         WR_START: next_state = WR_WAIT;
         WR_WAIT: begin
            if (timeout_hit)      next_state = ERROR;
            else if (wr_all_done) next_state = RD_START;
         end
         RD_START: next_state = RD_WAIT;
         RD_WAIT: begin
            if (timeout_hit)      next_state = ERROR;
            else if (rd_all_done) next_state = NEXT;
         end
         NEXT: begin
`ifdef BYTE_VERIFICATION_PHASE_EN
            if (last_phase) next_state = BV_START;
`else
            if (last_phase) next_state = DONE;
`endif
            else            next_state = WR_START;
         end
`ifdef BYTE_VERIFICATION_PHASE_EN
         BV_START: next_state = BV_WAIT;
         BV_WAIT: begin
            if (timeout_hit)                       next_state = ERROR;
            else if (byte_verification_phase_done) next_state = DONE;
         end
`endif
         DONE:     next_state = DONE;
         ERROR:    next_state = ERROR;
         default:  next_state = IDLE;
      endcase
   end

   // Phase index, sticky status flags and watchdog. Completion is flagged as
   // the final read pair finishes, so it is already visible while in NEXT and
   // leads the BV start pulse by one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         current_phase            <= '0;
         test_execution_completed <= 1'b0;
         phase_timeout            <= 1'b0;
         wd_cnt                   <= '0;
      end else begin
         if (state == IDLE && start)
            current_phase <= '0;
         else if (state == NEXT && !last_phase)
            current_phase <= current_phase + 1'b1;

         if (state == RD_WAIT && next_state == NEXT && last_phase)
            test_execution_completed <= 1'b1;

         if (timeout_hit)
            phase_timeout <= 1'b1;

         if (next_state != state)
            wd_cnt <= '0;
         else if (in_wait)
            wd_cnt <= wd_cnt + 1'b1;
      end
   end

`ifdef BYTE_VERIFICATION_PHASE_EN
   // Sticky record that the byte verification phase finished in time.
   always_ff @(posedge clk) begin
      if (rst)
         byte_verification_phase_done_latched <= 1'b0;
      else if (state == BV_WAIT && !timeout_hit && byte_verification_phase_done)
         byte_verification_phase_done_latched <= 1'b1;
   end
`endif

   // Start pulses and busy are pure decodes of the current state.
   always_comb begin
      write_addr_phase_start = (state == WR_START);
      write_data_phase_start = (state == WR_START);
      read_addr_phase_start  = (state == RD_START);
      read_data_phase_start  = (state == RD_START);
`ifdef BYTE_VERIFICATION_PHASE_EN
      byte_verification_phase_start = (state == BV_START);
`endif
      busy = !((state == IDLE) || (state == DONE) || (state == ERROR));
   end

endmodule

// File: tb/tb_axi_phase_sequencer.sv
// ---------------------------------------------------------------------------
// tb_axi_phase_sequencer
// Self-checking bench for axi_phase_sequencer. The bench plays the four
// channel agents: each start pulse schedules its done pulse a (usually
// random) number of cycles later. A scoreboard derives from those schedules
// when the next start pulse, completion, timeout or reset effect must appear.
// Build with BYTE_VERIFICATION_PHASE_EN to also exercise the BV phase.
// ---------------------------------------------------------------------------
module tb_axi_phase_sequencer;

   localparam int TOTAL      = 64;
   localparam int PER_PHASE  = 8;
   localparam int NUM_PHASES = TOTAL / PER_PHASE;
   localparam int TIMEOUT    = 20;
   localparam int PW         = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          aw_done, w_done, ar_done, r_done;
   logic          aw_start, w_start, ar_start, r_start;
   logic [PW-1:0] current_phase;
   logic          completed;
   logic          phase_timeout;
   logic          busy;
   logic          bv_done;
   logic          bv_start;
   logic          bv_latched;

   int tests_run    = 0;
   int tests_failed = 0;
   int cyc          = 0;

   // Scenario settings read by runSequence; -1 disables a setting.
   int fixed_delay    = 0;
   int early_w_phase  = -1;
   int same_rd_phase  = -1;
   int withhold_phase = -1;
   int reset_phase    = -1;

   axi_phase_sequencer #(
      .TOTAL_TEST_COUNT     (TOTAL),
      .PHASE_TEST_COUNT     (PER_PHASE),
      .PHASE_TIMEOUT_CYCLES (TIMEOUT),
      .PHASE_W              (PW)
   ) dut (
      .clk                      (clk),
      .rst                      (rst),
      .start                    (start),
      .write_addr_phase_done    (aw_done),
      .write_data_phase_done    (w_done),
      .read_addr_phase_done     (ar_done),
      .read_data_phase_done     (r_done),
      .write_addr_phase_start   (aw_start),
      .write_data_phase_start   (w_start),
      .read_addr_phase_start    (ar_start),
      .read_data_phase_start    (r_start),
      .current_phase            (current_phase),
      .test_execution_completed (completed),
      .phase_timeout            (phase_timeout),
`ifdef BYTE_VERIFICATION_PHASE_EN
      .byte_verification_phase_start        (bv_start),
      .byte_verification_phase_done         (bv_done),
      .byte_verification_phase_done_latched (bv_latched),
`endif
      .busy                     (busy)
   );

`ifndef BYTE_VERIFICATION_PHASE_EN
   assign bv_start   = 1'b0;
   assign bv_latched = 1'b0;
`endif

   // Free-running bench clock.
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, actual, expected, cyc);
      end
   endtask

   // Drives every DUT input for the current cycle.
   task automatic applyStimulus(input logic st, input logic aw, input logic w, input logic ar,
                                input logic r, input logic bv, input logic rs);
      start   = st;
      aw_done = aw;
      w_done  = w;
      ar_done = ar;
      r_done  = r;
      bv_done = bv;
      rst     = rs;
   endtask

   // Advance one cycle and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   function automatic int pickDelay();
      if (fixed_delay > 0) return fixed_delay;
      return int'($urandom_range(8, 1));
   endfunction

   function automatic int maxOf(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Every output should read zero straight after reset.
   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_pulses"}, {aw_start, w_start, ar_start, r_start, bv_start}, 5'b0);
      checkOutput({tag, "_phase"}, current_phase, 0);
      checkOutput({tag, "_flags"}, {completed, phase_timeout, busy, bv_latched}, 4'b0);
   endtask

   task automatic doReset();
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      tick();
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      tick();
      checkResetOutputs("post_reset");
   endtask

   // Starts the DUT from IDLE and scores one run. Outcome: 0 completed,
   // 1 watchdog timeout, 2 reset mid-phase, -1 cycle budget exhausted.
   task automatic runSequence(output int outcome);
      int model_phase = 0;
      int exp_wr = -1, exp_rd = -1, exp_cmp = -1;
      int aw_c = -1, w_c = -1, ar_c = -1, r_c = -1, bv_c = -1;
      int to_cyc = -1, rst_cyc = -1, end_cyc = -1;
      int wr_sig_pulses = 0, rd_sig_pulses = 0, bv_pulses = 0;
      int da, dw, dar, dr;
      bit finished = 0;
      outcome = -1;

      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      exp_wr = cyc + 1;

      for (int n = 0; n < 4000 && !finished; n++) begin
         tick();

         if (aw_start || w_start) begin
            checkOutput("wr_pulse_pair", {aw_start, w_start}, 2'b11);
            checkOutput("wr_pulse_cycle", cyc, exp_wr);
            checkOutput("wr_pulse_phase", current_phase, model_phase);
            checkOutput("wr_busy", busy, 1);
            wr_sig_pulses += int'(aw_start) + int'(w_start);
            exp_wr = -1;
            da = pickDelay();
            dw = pickDelay();
            if (model_phase == early_w_phase) begin
               dw = 1;
               da = 6;
            end
            aw_c = cyc + da;
            w_c  = cyc + dw;
            exp_rd = maxOf(aw_c, w_c) + 1;
            if (model_phase == reset_phase) begin
               aw_c    = cyc + 2;
               w_c     = -1;
               rst_cyc = cyc + 2;
               exp_rd  = -1;
            end
         end

         if (ar_start || r_start) begin
            checkOutput("rd_pulse_pair", {ar_start, r_start}, 2'b11);
            checkOutput("rd_pulse_cycle", cyc, exp_rd);
            checkOutput("rd_pulse_phase", current_phase, model_phase);
            rd_sig_pulses += int'(ar_start) + int'(r_start);
            exp_rd = -1;
            dar = pickDelay();
            dr  = (model_phase == same_rd_phase) ? dar : pickDelay();
            ar_c = cyc + dar;
            r_c  = cyc + dr;
            if (model_phase == withhold_phase) begin
               r_c    = -1;
               to_cyc = cyc + TIMEOUT;
            end else if (model_phase < NUM_PHASES - 1) begin
               model_phase++;
               exp_wr = maxOf(ar_c, r_c) + 2;
            end else begin
               exp_cmp = maxOf(ar_c, r_c) + 1;
            end
         end

         if (bv_start) begin
            bv_pulses++;
            checkOutput("bv_start_cycle", cyc, exp_cmp + 1);
            bv_c = cyc + 10;
         end

         // Completion: flag rises the cycle after the last read done.
         if (exp_cmp >= 0 && cyc == exp_cmp - 1)
            checkOutput("completed_not_early", completed, 0);
         if (exp_cmp >= 0 && cyc == exp_cmp) begin
            checkOutput("completed_set", completed, 1);
            checkOutput("completed_phase", current_phase, NUM_PHASES - 1);
         end
`ifdef BYTE_VERIFICATION_PHASE_EN
         if (bv_c >= 0 && cyc == bv_c)
            checkOutput("bv_latched_not_early", bv_latched, 0);
         if (bv_c >= 0 && cyc == bv_c + 1) begin
            checkOutput("bv_latched_set", bv_latched, 1);
            checkOutput("bv_done_idle", busy, 0);
            end_cyc = cyc + 6;
         end
`else
         if (exp_cmp >= 0 && cyc == exp_cmp + 1) begin
            checkOutput("done_idle", busy, 0);
            checkOutput("done_completed", completed, 1);
            end_cyc = cyc + 6;
         end
`endif

         // Watchdog: quiet through the 20th wait cycle, raised just after.
         if (to_cyc >= 0 && cyc == to_cyc)
            checkOutput("timeout_not_early", phase_timeout, 0);
         if (to_cyc >= 0 && cyc == to_cyc + 1) begin
            checkOutput("timeout_set", phase_timeout, 1);
            checkOutput("timeout_idle", busy, 0);
            checkOutput("timeout_phase", current_phase, withhold_phase);
            checkOutput("timeout_not_completed", completed, 0);
            outcome = 1;
            end_cyc = cyc + 8;
         end

         if (rst_cyc >= 0 && cyc == rst_cyc + 1) begin
            checkResetOutputs("mid_phase_reset");
            outcome = 2;
            end_cyc = cyc + 4;
         end

         if (end_cyc >= 0 && cyc == end_cyc) begin
            finished = 1;
            if (outcome < 0) begin
               checkOutput("wr_signal_pulses", wr_sig_pulses, 2 * NUM_PHASES);
               checkOutput("rd_signal_pulses", rd_sig_pulses, 2 * NUM_PHASES);
               checkOutput("final_phase", current_phase, NUM_PHASES - 1);
`ifdef BYTE_VERIFICATION_PHASE_EN
               checkOutput("bv_pulse_count", bv_pulses, 1);
`endif
               outcome = 0;
            end
         end

         applyStimulus(0, cyc == aw_c, cyc == w_c, cyc == ar_c, cyc == r_c,
                       cyc == bv_c, cyc == rst_cyc);
      end

      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      if (!finished) checkOutput("cycle_budget", 0, 1);
   endtask

   // Scenario list.
   initial begin
      int outcome;
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      tick();
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      tick();
      checkResetOutputs("reset");

      // Every done three cycles after its start.
      fixed_delay = 3;
      runSequence(outcome);
      checkOutput("fixed_outcome", outcome, 0);

      // DONE is terminal: start must not relaunch anything.
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("done_ignores_start", {aw_start, ar_start, busy, completed}, 4'b0001);
      end
      doReset();

      // Random delays, W ahead of AW in phase 2, simultaneous read dones in phase 4.
      fixed_delay   = 0;
      early_w_phase = 2;
      same_rd_phase = 4;
      runSequence(outcome);
      checkOutput("random_outcome", outcome, 0);
      doReset();

      // R done withheld in phase 1.
      early_w_phase  = -1;
      same_rd_phase  = -1;
      withhold_phase = 1;
      runSequence(outcome);
      checkOutput("timeout_outcome", outcome, 1);
      doReset();

      // Reset in the middle of phase 3's write wait.
      withhold_phase = -1;
      reset_phase    = 3;
      runSequence(outcome);
      checkOutput("reset_outcome", outcome, 2);

      // Stale dones in IDLE must be ignored, then a clean restart from phase 0.
      applyStimulus(0, 1, 1, 1, 1, 1, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      tick();
      checkOutput("stale_done_idle", {busy, aw_start, ar_start}, 3'b0);
      checkOutput("stale_done_phase", current_phase, 0);
      reset_phase = -1;
      runSequence(outcome);
      checkOutput("restart_outcome", outcome, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
